// File: rtl/jtframe_ddr_arb_pkg.sv
// Shared types and constants for the two-client DDR arbiter.
package jtframe_ddr_arb_pkg;

    localparam int BCW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_DATA = 2'd3
    } st_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // A zero burst count still moves one beat.
    function automatic logic [BCW-1:0] beats_of(input logic [BCW-1:0] bc);
        return (bc == '0) ? BCW'(1) : bc;
    endfunction

endpackage

// File: rtl/jtframe_ddr_arb.sv
// Burst-granular arbiter sharing one DDR port between a read/write client A and a read-only client B.
// Define JTFRAME_DDR_ARB_RR_EN for round-robin tie breaking; otherwise A always wins ties.
module jtframe_ddr_arb
    import jtframe_ddr_arb_pkg::*;
#(
    parameter int AW = 29,
    parameter int DW = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_rd,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [BCW-1:0]    a_burstcnt,
    input  logic [DW-1:0]     a_din,
    input  logic [DW/8-1:0]   a_be,
    output logic              a_busy,
    output logic              a_dout_ready,
    input  logic              b_rd,
    input  logic [AW-1:0]     b_addr,
    input  logic [BCW-1:0]    b_burstcnt,
    output logic              b_busy,
    output logic              b_dout_ready,
    output logic              ddram_clk,
    input  logic              ddram_busy,
    output logic [BCW-1:0]    ddram_burstcnt,
    output logic [AW-1:0]     ddram_addr,
    input  logic [DW-1:0]     ddram_dout,
    input  logic              ddram_dout_ready,
    output logic              ddram_rd,
    output logic [DW-1:0]     ddram_din,
    output logic [DW/8-1:0]   ddram_be,
    output logic              ddram_we
);

    st_e            st_q, st_d;
    logic           own_q, own_d;
    logic [BCW-1:0] cnt_q, cnt_d;
    logic           a_req, b_req, win_b;

    // Read data is fanned out to the clients outside this block.
    logic dout_unused;
    assign dout_unused = ^ddram_dout;

    assign ddram_clk = clk;
    assign a_req     = a_rd | a_we;
    assign b_req     = b_rd;

`ifdef JTFRAME_DDR_ARB_RR_EN
    logic last_q, last_d;

    // On a tie, whoever did not own the previous burst goes first.
    assign win_b = b_req & (~a_req | (last_q == OWN_A));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= OWN_B;
        else     last_q <= last_d;
    end

    always_comb begin
        last_d = last_q;
        if (st_q == IDLE && (a_req || b_req)) last_d = win_b;
    end
`else
    assign win_b = b_req & ~a_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= IDLE;
            own_q <= OWN_A;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            own_q <= own_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        own_d = own_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE: begin
                if (a_req || b_req) begin
                    own_d = win_b;
                    cnt_d = beats_of(win_b ? b_burstcnt : a_burstcnt);
                    st_d  = (!win_b && a_we) ? WR : RD_CMD;
                end
            end
            WR: begin
                if (a_we && !ddram_busy) begin
                    cnt_d = cnt_q - BCW'(1);
                    if (cnt_q <= BCW'(1)) st_d = IDLE;
                end
            end
            RD_CMD: begin
                if (ddram_rd && !ddram_busy) st_d = RD_DATA;
            end
            RD_DATA: begin
                if (ddram_dout_ready) begin
                    cnt_d = cnt_q - BCW'(1);
                    if (cnt_q <= BCW'(1)) st_d = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Command path is a live mux of the owner; beats outside RD_DATA are swallowed.
    always_comb begin
        a_busy         = 1'b1;
        b_busy         = 1'b1;
        a_dout_ready   = 1'b0;
        b_dout_ready   = 1'b0;
        ddram_burstcnt = '0;
        ddram_addr     = '0;
        ddram_rd       = 1'b0;
        ddram_we       = 1'b0;
        ddram_din      = '0;
        ddram_be       = '0;
        if (st_q != IDLE) begin
            if (own_q == OWN_A) begin
                ddram_addr     = a_addr;
                ddram_burstcnt = a_burstcnt;
                ddram_din      = a_din;
                ddram_be       = a_be;
                ddram_we       = (st_q == WR) && a_we;
                ddram_rd       = (st_q == RD_CMD) && a_rd;
                a_busy         = ddram_busy;
            end else begin
                ddram_addr     = b_addr;
                ddram_burstcnt = b_burstcnt;
                ddram_be       = '1;
                ddram_rd       = (st_q == RD_CMD) && b_rd;
                b_busy         = ddram_busy;
            end
            if (st_q == RD_DATA) begin
                a_busy       = 1'b1;
                b_busy       = 1'b1;
                a_dout_ready = (own_q == OWN_A) && ddram_dout_ready;
                b_dout_ready = (own_q == OWN_B) && ddram_dout_ready;
            end
        end
    end

endmodule

// File: doc/jtframe_ddr_arb.md
Name: jtframe_ddr_arb

Overview:
- Two-master arbiter placed directly downstream of the line-frame-buffer DDR controller. It shares the single MiSTer DDR3 port between two clients.
- Client A is the frame-buffer master: read/write, high priority.
- Client B is a read-only master, e.g. a ROM/sample streamer.
- Each grant is held for a whole burst. Read data (ddram_dout) goes straight to both clients; only the dout_ready strobe is routed to the owner.

Parameters:
- AW, 29, DDR word address width
- DW, 64, DDR data width; byte-enable width is DW/8

Ports:
- clk  in  1  system clock; also drives ddram_clk
- rst  in  1  asynchronous reset, active-high
- a_rd  in  1  client A read request, level, held until accepted
- a_we  in  1  client A write beat valid
- a_addr  in  AW  client A burst start address
- a_burstcnt  in  8  client A burst length
- a_din  in  DW  client A write data
- a_be  in  DW/8  client A byte enables
- a_busy  out  1  client A stall
- a_dout_ready  out  1  read beat valid for client A
- b_rd  in  1  client B read request
- b_addr  in  AW  client B burst start address
- b_burstcnt  in  8  client B burst length
- b_busy  out  1  client B stall
- b_dout_ready  out  1  read beat valid for client B
- ddram_clk  out  1  equals clk
- ddram_busy  in  1  DDR stall
- ddram_burstcnt  out  8
- ddram_addr  out  AW
- ddram_dout  in  DW  also wired to both clients outside this block
- ddram_dout_ready  in  1
- ddram_rd  out  1
- ddram_din  out  DW
- ddram_be  out  DW/8
- ddram_we  out  1

Behaviour:
- State register `st`: IDLE, WR, RD_CMD, RD_DATA. Owner register `own`: 0=A, 1=B. Beat counter `cnt`: 8 bits.
- Reset: st=IDLE, own=0, cnt=0. All ddram_rd/we/burstcnt/addr/din/be outputs are 0. a_busy=b_busy=1. a/b_dout_ready=0.
- IDLE:
  - a_busy=b_busy=1; no DDR command is issued.
  - Each cycle, pick the winner among pending requests (a_rd|a_we, b_rd) under the priority rule.
  - Register own, load cnt with the winner's burstcnt (value 0 is treated as 1).
  - Next state is WR if a_we, else RD_CMD.
  - Grant latency: a request seen at cycle N is forwarded to DDR from cycle N+1.
- Granted states:
  - DDR command outputs mux combinationally from the owner's inputs.
  - Owner busy = ddram_busy; the non-owner's busy = 1.
  - Client B drives ddram_we=0 and ddram_be=all ones.
- WR:
  - Each beat accepted (a_we & ~ddram_busy) decrements cnt.
  - When the beat that takes cnt 1→0 is accepted, go to IDLE on the next cycle.
  - a_we low mid-burst just pauses the burst; there is no timeout.
- RD_CMD: when ddram_rd & ~ddram_busy, go to RD_DATA. ddram_rd drops in RD_DATA.
- RD_DATA:
  - ddram_rd=0; owner busy=1.
  - Each ddram_dout_ready pulses the owner's dout_ready in the same cycle (combinational) and decrements cnt.
  - At the last beat, return to IDLE.
- ddram_dout_ready outside RD_DATA is dropped; neither client sees it. This includes stale beats after a mid-burst reset.
- Priority (default): fixed, A over B. When A and B request in the same IDLE cycle, A wins.
- Address and burstcnt are sampled live from the owner. Clients must hold them stable until accepted (MiSTer DDR convention).
- Reset mid-burst: immediate return to the reset state. The DDR side may still deliver data; it is discarded as above.

Optional Feature:
- Macro: JTFRAME_DDR_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit `last` register records the previous owner; on a simultaneous request the other client wins. `last` resets to 1, so A wins the first tie.
- Undefined: fixed priority to A; the `last` register is not built.

Decomposition:
- Package jtframe_ddr_arb_pkg holds:
  - state enum (IDLE=2'd0, WR=2'd1, RD_CMD=2'd2, RD_DATA=2'd3)
  - owner localparams OWN_A=0, OWN_B=1
  - burstcnt width constant 8
- No sub-module: the output mux and the FSM stay in one file.

Test Plan:
- Reset mid-RD_DATA (A burst of 4, after 2 beats) → outputs return to reset values within the same cycle. The next 2 ddram_dout_ready pulses produce no a/b_dout_ready.
- A read, burstcnt=4, ddram_busy=0:
  - ddram_rd high exactly 1 cycle, starting 1 cycle after a_rd.
  - Four ddram_dout_ready pulses → four a_dout_ready pulses, b_dout_ready stays 0.
  - FSM back in IDLE the cycle after beat 4.
- A write, burstcnt=8, ddram_busy high on beats 3 and 6 → exactly 8 accepted beats, with ddram_be/din equal to a_be/a_din on each, then IDLE.
- a_rd and b_rd rise on the same cycle, both burstcnt=2:
  - Default build: A served fully, then B, with b_busy=1 throughout A's burst.
  - With RD_EN variant (JTFRAME_DDR_ARB_RR_EN): ties alternate B,A on the next two rounds.
- b_rd with b_burstcnt=0 → treated as a 1-beat read; one b_dout_ready, then IDLE.
